// File: rtl/fnd_scan_driver.sv
// 4-digit common-anode 7-segment scan driver fed by a sequential double-dabble converter.
// The binary input is re-converted continuously; digits are multiplexed one slot at a time.
module fnd_scan_driver #(
  parameter int SCAN_DIV  = 100_000,
  parameter int MAX_VALUE = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] fnd_in_data,
  input  logic        i_blank_en,
  input  logic [3:0]  i_dp,
  output logic [3:0]  fnd_digit,
  output logic [7:0]  fnd_data,
  output logic        o_bcd_valid
);

  localparam int                CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [13:0]       MAX_V    = 14'(MAX_VALUE);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  iter_q, iter_d;
  logic [15:0] disp_q, disp_d;
  logic        valid_q, valid_d;
  logic [15:0] bcd_adj;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                               : bcd_q[gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    disp_d  = disp_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        bin_d   = (fnd_in_data > MAX_V) ? MAX_V : fnd_in_data;
        bcd_d   = '0;
        iter_d  = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // Adjust-then-shift: the binary MSB moves into the BCD LSB.
        bcd_d  = {bcd_adj[14:0], bin_q[13]};
        bin_d  = {bin_q[12:0], 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd13) state_d = S_DONE;
      end
      S_DONE: begin
        disp_d  = bcd_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      disp_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
      disp_q  <= disp_d;
      valid_q <= valid_d;
    end
  end

  // valid rises together with the new display contents
  assign o_bcd_valid = valid_q;

  // Scan timing
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             tick_q, tick_d;
  logic             terminal;

  assign terminal = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d  = terminal ? '0 : cnt_q + CNT_W'(1);
    sel_d  = terminal ? sel_q + 2'd1 : sel_q;
    tick_d = terminal;
  end

  // Leading-zero blanking mask; digit 0 is never blanked
  logic [3:0] blank_vec;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_blank
      if (gi == 0) begin : g_ones
        assign blank_vec[gi] = 1'b0;
      end else begin : g_upper
        assign blank_vec[gi] = i_blank_en && (disp_q[15:gi*4] == '0);
      end
    end
  endgenerate

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  logic [3:0] nib_sel;
  logic [3:0] digit_d;
  logic [7:0] seg_d;
  logic [3:0] digit_q;
  logic [7:0] seg_q;

  assign nib_sel = disp_q[sel_q*4 +: 4];

  always_comb begin
    digit_d = ~(4'b0001 << sel_q);
    seg_d   = {~i_dp[sel_q], blank_vec[sel_q] ? 7'h7F : seg7(nib_sel)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      sel_q   <= 2'd3;
      tick_q  <= 1'b0;
      digit_q <= 4'b1111;
      seg_q   <= 8'hFF;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      tick_q <= tick_d;
      // Digit enable and segments load on the same edge to avoid ghosting
      if (tick_q) begin
        digit_q <= digit_d;
        seg_q   <= seg_d;
      end
    end
  end

  assign fnd_digit = digit_q;
  assign fnd_data  = seg_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed bench for fnd_scan_driver with a short scan period.
module tb_fnd_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] fnd_in_data;
  logic        i_blank_en;
  logic [3:0]  i_dp;
  logic [3:0]  fnd_digit;
  logic [7:0]  fnd_data;
  logic        o_bcd_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fnd_scan_driver #(.SCAN_DIV(4), .MAX_VALUE(9999)) dut (
    .clk         (clk),
    .reset       (reset),
    .fnd_in_data (fnd_in_data),
    .i_blank_en  (i_blank_en),
    .i_dp        (i_dp),
    .fnd_digit   (fnd_digit),
    .fnd_data    (fnd_data),
    .o_bcd_valid (o_bcd_valid)
  );

  // Waits for the next digit slot (digit enable change), bounded.
  task automatic read_slot(output logic [3:0] dig, output logic [7:0] dat);
    logic [3:0] prev;
    int n;
    prev = fnd_digit;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fnd_digit === prev && n < 20);
    if (fnd_digit === prev) begin
      checks++;
      errors++;
      $display("FAIL slot_timeout: fnd_digit stuck at %b, required a change within 20 clk", prev);
    end
    dig = fnd_digit;
    dat = fnd_data;
  endtask

  task automatic get_digit(input int k, output logic [7:0] dat);
    logic [3:0] want, d;
    logic [7:0] s;
    bit found;
    want = ~(4'b0001 << k);
    found = 0;
    dat = 8'hxx;
    for (int i = 0; i < 8 && !found; i++) begin
      read_slot(d, s);
      if (d === want) begin
        found = 1;
        dat = s;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL digit_missing: digit %0d never enabled, required fnd_digit=%b", k, want);
    end
  endtask

  task automatic read_digits(output logic [7:0] d0, output logic [7:0] d1,
                             output logic [7:0] d2, output logic [7:0] d3);
    get_digit(0, d0);
    get_digit(1, d1);
    get_digit(2, d2);
    get_digit(3, d3);
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    ok = 0;
    while (n < 40 && !ok) begin
      @(negedge clk);
      n++;
      if (o_bcd_valid === 1'b1) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: o_bcd_valid not seen within 40 clk");
    end
  endtask

  task automatic test_reset();
    logic [3:0] d;
    logic [7:0] s;
    reset = 1'b1;
    fnd_in_data = 14'd0;
    i_blank_en = 1'b0;
    i_dp = 4'b0000;
    repeat (3) @(negedge clk);
    checks++;
    if (fnd_digit !== 4'b1111) begin
      errors++;
      $display("FAIL reset_digit: got %b, required 1111", fnd_digit);
    end
    checks++;
    if (fnd_data !== 8'hFF) begin
      errors++;
      $display("FAIL reset_data: got %h, required FF", fnd_data);
    end
    checks++;
    if (o_bcd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b, required 0", o_bcd_valid);
    end
    reset = 1'b0;
    read_slot(d, s);
    checks++;
    if (d !== 4'b1110 || s !== 8'hC0) begin
      errors++;
      $display("FAIL first_slot: got %b/%h, required 1110/C0", d, s);
    end
    $display("test_reset: first slot %b/%h", d, s);
  endtask

  task automatic test_1234();
    logic [7:0] exp [4];
    logic [3:0] d;
    logic [7:0] s;
    int k0, k, n;
    bit ok;
    exp[0] = 8'h99; exp[1] = 8'hB0; exp[2] = 8'hA4; exp[3] = 8'hF9;
    fnd_in_data = 14'd1234;
    i_blank_en = 1'b0;
    i_dp = 4'b0000;
    repeat (40) @(negedge clk);
    read_slot(d, s);
    k0 = -1;
    for (int j = 0; j < 4; j++) if (d === ~(4'b0001 << j)) k0 = j;
    checks++;
    if (k0 < 0) begin
      errors++;
      $display("FAIL scan_onehot: got %b, required one active-low bit", d);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (i > 0) read_slot(d, s);
        k = (k0 + i) % 4;
        checks++;
        if (d !== ~(4'b0001 << k) || s !== exp[k]) begin
          errors++;
          $display("FAIL scan_1234_slot%0d: got %b/%h, required %b/%h", i, d, s,
                   ~(4'b0001 << k), exp[k]);
        end
        $display("test_1234: slot %b/%h", d, s);
      end
    end
    wait_valid(ok);
    if (ok) begin
      @(negedge clk);
      checks++;
      if (o_bcd_valid !== 1'b0) begin
        errors++;
        $display("FAIL valid_width: got %b one clk after pulse, required 0", o_bcd_valid);
      end
      n = 1;
      while (n < 40 && o_bcd_valid !== 1'b1) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n != 16) begin
        errors++;
        $display("FAIL valid_period: got %0d clk, required 16", n);
      end
      $display("test_1234: valid period %0d", n);
    end
  endtask

  task automatic test_zero_blank();
    logic [7:0] g [4];
    fnd_in_data = 14'd0;
    i_blank_en = 1'b1;
    i_dp = 4'b0000;
    repeat (40) @(negedge clk);
    read_digits(g[0], g[1], g[2], g[3]);
    checks++;
    if (g[0] !== 8'hC0 || g[1] !== 8'hFF || g[2] !== 8'hFF || g[3] !== 8'hFF) begin
      errors++;
      $display("FAIL zero_blank_on: got %h %h %h %h, required C0 FF FF FF", g[0], g[1], g[2], g[3]);
    end
    $display("test_zero_blank on: %h %h %h %h", g[0], g[1], g[2], g[3]);
    i_blank_en = 1'b0;
    read_digits(g[0], g[1], g[2], g[3]);
    checks++;
    if (g[0] !== 8'hC0 || g[1] !== 8'hC0 || g[2] !== 8'hC0 || g[3] !== 8'hC0) begin
      errors++;
      $display("FAIL zero_blank_off: got %h %h %h %h, required C0 C0 C0 C0", g[0], g[1], g[2], g[3]);
    end
    $display("test_zero_blank off: %h %h %h %h", g[0], g[1], g[2], g[3]);
  endtask

  task automatic test_clamp();
    logic [7:0] g [4];
    logic [13:0] vals [2];
    vals[0] = 14'd16383;
    vals[1] = 14'd10000;
    i_blank_en = 1'b0;
    i_dp = 4'b0000;
    for (int v = 0; v < 2; v++) begin
      fnd_in_data = vals[v];
      repeat (40) @(negedge clk);
      read_digits(g[0], g[1], g[2], g[3]);
      checks++;
      if (g[0] !== 8'h90 || g[1] !== 8'h90 || g[2] !== 8'h90 || g[3] !== 8'h90) begin
        errors++;
        $display("FAIL clamp_%0d: got %h %h %h %h, required 90 90 90 90", vals[v],
                 g[0], g[1], g[2], g[3]);
      end
      $display("test_clamp %0d: %h %h %h %h", vals[v], g[0], g[1], g[2], g[3]);
    end
  endtask

  task automatic test_dp_blank();
    logic [7:0] g [4];
    fnd_in_data = 14'd5;
    i_blank_en = 1'b1;
    i_dp = 4'b0100;
    repeat (40) @(negedge clk);
    read_digits(g[0], g[1], g[2], g[3]);
    checks++;
    if (g[0] !== 8'h92 || g[1] !== 8'hFF || g[2] !== 8'h7F || g[3] !== 8'hFF) begin
      errors++;
      $display("FAIL dp_blank: got %h %h %h %h, required 92 FF 7F FF", g[0], g[1], g[2], g[3]);
    end
    $display("test_dp_blank: %h %h %h %h", g[0], g[1], g[2], g[3]);
  endtask

  task automatic test_midshift();
    logic [7:0] g [4];
    logic [3:0] d;
    logic [7:0] s;
    bit ok;
    fnd_in_data = 14'd9999;
    i_blank_en = 1'b0;
    i_dp = 4'b0000;
    repeat (40) @(negedge clk);
    wait_valid(ok);
    repeat (3) @(negedge clk);
    fnd_in_data = 14'd0;
    repeat (32) @(negedge clk);
    read_digits(g[0], g[1], g[2], g[3]);
    checks++;
    if (g[0] !== 8'hC0 || g[1] !== 8'hC0 || g[2] !== 8'hC0 || g[3] !== 8'hC0) begin
      errors++;
      $display("FAIL midshift_change: got %h %h %h %h, required C0 C0 C0 C0", g[0], g[1], g[2], g[3]);
    end
    $display("test_midshift change: %h %h %h %h", g[0], g[1], g[2], g[3]);

    fnd_in_data = 14'd1234;
    repeat (40) @(negedge clk);
    wait_valid(ok);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (fnd_digit !== 4'b1111 || fnd_data !== 8'hFF || o_bcd_valid !== 1'b0) begin
      errors++;
      $display("FAIL midshift_reset: got %b/%h/%b, required 1111/FF/0", fnd_digit, fnd_data, o_bcd_valid);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    read_slot(d, s);
    checks++;
    if (d !== 4'b1110 || s !== 8'hC0) begin
      errors++;
      $display("FAIL post_reset_slot: got %b/%h, required 1110/C0", d, s);
    end
    $display("test_midshift reset: first slot %b/%h", d, s);
    repeat (40) @(negedge clk);
    get_digit(0, s);
    checks++;
    if (s !== 8'h99) begin
      errors++;
      $display("FAIL post_reset_value: digit0 got %h, required 99", s);
    end
    $display("test_midshift reset: digit0 %h", s);
  endtask

  initial begin
    test_reset();
    test_1234();
    test_zero_blank();
    test_clamp();
    test_dp_blank();
    test_midshift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
